inst_fetch: RTL
===============

Name: inst_fetch

Overview:
Instruction-fetch stage of the 5-stage MIPS pipeline. It drives the PC, issues word reads to instruction memory over a req/ack handshake, and buffers returned words with their PC in a small prefetch FIFO. It presents {inst, pc} to ID, which the decode/hazard controller reads as `inst`, and it obeys the controller's if_en/if_rst plus a branch/jump redirect from EXE.

Parameters:
PC_RESET, 32'h0000_0000, fetch PC after reset or if_rst
FIFO_DEPTH, 2, prefetch entries (power of 2, >=2)

Ports:
clk  in  1  main clock
rst  in  1  reset, asynchronous, active-high
if_en  in  1  controller stage enable; 0 blocks issuing new requests
if_rst  in  1  controller synchronous flush
id_en  in  1  ID stage accepts head entry this cycle
redirect  in  1  taken branch/jump from EXE
redirect_pc  in  32  redirect target
imem_req  out  1  fetch request
imem_addr  out  32  fetch word address
imem_ack  in  1  response valid; may assert in the request cycle (zero-wait) or later
imem_rdata  in  32  instruction word, valid with imem_ack
id_valid  out  1  head entry valid
id_inst  out  32  head instruction; 32'h0 when empty
id_pc  out  32  PC of id_inst
id_pc_next  out  32  id_pc+4

Behaviour:
- Reset (async): fetch_pc=PC_RESET; FIFO empty; state RUN. Outputs: imem_req=0, imem_addr=PC_RESET, id_valid=0, id_inst=0, id_pc=0, id_pc_next=4.
- At most one request is outstanding. imem_req and imem_addr stay stable from assertion until the cycle imem_ack=1.
- FSM:
  - RUN: assert imem_req when if_en=1 and count<FIFO_DEPTH. The count includes the outstanding slot. Stay in RUN on a same-cycle ack; otherwise go to WAIT.
  - WAIT: hold the request. On ack, push {fetch_pc, rdata}, set fetch_pc+=4, and return to RUN.
  - DROP: the outstanding request is stale. Keep imem_req asserted with its original address until ack, discard the data, then go to RUN.
- Latency: ack in cycle k makes the entry visible to ID at k+1. There is no bypass. A zero-wait memory sustains 1 inst/cycle with FIFO_DEPTH>=2.
- Pop: the head is removed on the clock edge where id_valid=1 and id_en=1. Push and pop in the same cycle at full is legal, and count is unchanged.
- Full: no new request is issued. The outstanding ack is always accepted, because space was reserved for it.
- Empty: id_valid=0 and id_inst=32'h0. The controller decodes this as an unrecognized instruction and writes nothing back.
- redirect=1:
  - Flush the FIFO and set fetch_pc={redirect_pc[31:2],2'b00}.
  - If a request is outstanding with no ack this cycle, go to DROP. Otherwise go to RUN.
  - Any ack in the redirect cycle is discarded.
- if_rst=1: same flush as redirect, with target PC_RESET.
- Priority: rst > if_rst > redirect > ack/pop.
- Redirect while in DROP: update fetch_pc and stay in DROP.
- PC arithmetic is modulo 2^32: 32'hFFFF_FFFC+4 wraps to 0.
- if_en=0 does not cancel an outstanding request; its ack is still pushed. Pops are governed by id_en only.
- Async rst asserted mid-request: imem_req drops immediately. Memory must tolerate the abandoned request.

Optional Feature:
FETCH_STAT_EN: adds output ports stat_fetch_cnt[31:0] (count of accepted, non-discarded acks) and stat_flush_cnt[15:0] (count of redirect or if_rst cycles). Both saturate at all-ones and clear on rst. Without the macro these ports and their counters do not exist, and the behaviour is otherwise identical.

Decomposition:
- Shared package fetch_pkg holds:
  - state encoding (RUN, WAIT, DROP)
  - INST_NOP=32'h0
  - default PC_RESET
  - the FIFO entry type {pc[31:0], inst[31:0]}
- Sub-module fetch_fifo: synchronous FIFO with push/pop/flush, count output, head read; parameterized by FIFO_DEPTH.

Test Plan:
1. Zero-wait memory (ack=req), id_en=1, PC_RESET=0 -> imem_addr 0,4,8,...; id_valid from cycle 2; id_pc advances by 4 each cycle.
2. id_en=0 for 5 cycles -> at most 2 requests issued, then imem_req=0; on id_en=1, entries pop with pc 0 then 4, and fetching resumes at 8.
3. 3-cycle memory latency; redirect to 32'h100 one cycle after the request -> state DROP, stale ack discarded, next imem_addr=32'h100, first id_pc=32'h100.
4. redirect_pc=32'h203 with an ack in the same cycle -> ack data discarded; next fetch at 32'h200.
5. if_rst and redirect asserted together with PC_RESET=32'h400 -> FIFO empty, next imem_addr=32'h400.
6. fetch_pc=32'hFFFF_FFFC fetched -> id_pc_next=0 and the next imem_addr=0. Async rst pulse mid-WAIT -> imem_req=0 immediately and all outputs at reset values.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage:
// FSM encoding, the NOP presented to ID when empty, and the prefetch entry layout.
package fetch_pkg;

   typedef enum logic [1:0] {
      RUN  = 2'd0,
      WAIT = 2'd1,
      DROP = 2'd2
   } fetch_state_t;

   localparam logic [31:0] INST_NOP         = 32'h0000_0000;
   localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_0000;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO of {pc, inst} entries with push, pop, flush and an occupancy count.
// Flush wins over push/pop; the caller never pops an empty FIFO or pushes a full one.
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter  int DEPTH = 2,
   localparam int AW    = $clog2(DEPTH),
   localparam int CW    = AW + 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         flush,
   input  logic         push,
   input  fetch_entry_t push_data,
   input  logic         pop,
   output logic [CW-1:0] count,
   output fetch_entry_t head
);

   fetch_entry_t  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop)      count <= count + 1'b1;
         else if (pop && !push) count <= count - 1'b1;
      end
   end

   // Storage needs no reset: the head is only meaningful while count is non-zero.
   always_ff @(posedge clk) begin
      if (push && !flush) mem[wr_ptr] <= push_data;
   end

   assign head = mem[rd_ptr];

endmodule

// File: rtl/inst_fetch.sv
// MIPS IF stage: PC, single-outstanding imem req/ack, prefetch FIFO presenting {inst, pc} to ID.
// Define FETCH_STAT_EN to add the stat_fetch_cnt / stat_flush_cnt counters.
module inst_fetch
   import fetch_pkg::*;
#(
   parameter logic [31:0] PC_RESET   = PC_RESET_DEFAULT,
   parameter int          FIFO_DEPTH = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         if_en,
   input  logic         if_rst,
   input  logic         id_en,
   input  logic         redirect,
   input  logic [31:0]  redirect_pc,
   output logic         imem_req,
   output logic [31:0]  imem_addr,
   input  logic         imem_ack,
   input  logic [31:0]  imem_rdata,
   output logic         id_valid,
   output logic [31:0]  id_inst,
   output logic [31:0]  id_pc,
   output logic [31:0]  id_pc_next,
`ifdef FETCH_STAT_EN
   output logic [31:0]  stat_fetch_cnt,
   output logic [15:0]  stat_flush_cnt,
`endif
   output fetch_state_t dbg_state
);

   localparam int            CW      = $clog2(FIFO_DEPTH) + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

   fetch_state_t  state, state_nxt;
   logic [31:0]   fetch_pc, req_addr, flush_pc;
   logic [CW-1:0] count;
   fetch_entry_t  head, push_data;
   logic          flush, busy, push, pop;

   // imem handshake: once imem_req rises, imem_req/imem_addr hold until the cycle
   // imem_ack=1 (which may be the same cycle); that cycle completes the transfer.
   assign flush     = if_rst || redirect;
   assign flush_pc  = if_rst ? PC_RESET : {redirect_pc[31:2], 2'b00};
   assign busy      = imem_req && !imem_ack;
   assign push      = imem_req && imem_ack && (state != DROP) && !flush;
   assign pop       = id_valid && id_en && !flush;
   assign push_data = '{pc: imem_addr, inst: imem_rdata};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= RUN;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (flush) begin
         state_nxt = busy ? DROP : RUN;
      end else begin
         case (state)
            RUN:        state_nxt = busy ? WAIT : RUN;
            WAIT, DROP: state_nxt = imem_ack ? RUN : state;
            default:    state_nxt = RUN;
         endcase
      end
   end

   // Count < depth in RUN already accounts for the slot a new request reserves.
   always_comb begin
      imem_req  = 1'b0;
      imem_addr = fetch_pc;
      case (state)
         RUN:        imem_req = if_en && (count < DEPTH_C);
         WAIT, DROP: begin
            imem_req  = 1'b1;
            imem_addr = req_addr;
         end
         default:    imem_req = 1'b0;
      endcase
      if (rst) imem_req = 1'b0;
   end

   // req_addr keeps the original address of a request made stale by a redirect.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetch_pc <= PC_RESET;
         req_addr <= PC_RESET;
      end else begin
         if (state == RUN && imem_req) req_addr <= fetch_pc;
         if (flush)     fetch_pc <= flush_pc;
         else if (push) fetch_pc <= fetch_pc + 32'd4;
      end
   end

   fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .push      (push),
      .push_data (push_data),
      .pop       (pop),
      .count     (count),
      .head      (head)
   );

   assign id_valid   = (count != '0);
   assign id_inst    = id_valid ? head.inst : INST_NOP;
   assign id_pc      = id_valid ? head.pc : 32'h0;
   assign id_pc_next = id_pc + 32'd4;
   assign dbg_state  = state;

`ifdef FETCH_STAT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stat_fetch_cnt <= '0;
         stat_flush_cnt <= '0;
      end else begin
         if (push && stat_fetch_cnt != '1)  stat_fetch_cnt <= stat_fetch_cnt + 1'b1;
         if (flush && stat_flush_cnt != '1) stat_flush_cnt <= stat_flush_cnt + 1'b1;
      end
   end
`endif

endmodule
